// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/step/breakpoint clock controller.
// State encodings are visible on the state output, so their values are fixed.
package cpu_ctrl_pkg;

   localparam int CYC_W = 16;
   localparam int DIV_W = 26;
   localparam int DB_W  = 20;

   typedef enum logic [1:0] {
      WAIT = 2'b00,
      HI   = 2'b01,
      LO   = 2'b10,
      HALT = 2'b11
   } run_state_e;

endpackage

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability down-counter and
// rising-edge one-shot. A level is accepted after DB_CYC stable cycles.
module btn_debounce
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned DB_CYC = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic press
);

   localparam logic [DB_W-1:0] DB_RELOAD = DB_W'(DB_CYC - 1);

   logic [1:0]      sync_q;
   logic            stable_q, stable_d;
   logic [DB_W-1:0] cnt_q, cnt_d;
   logic            press_q, press_d;

   // Any sample equal to the accepted level restarts the stability window.
   always_comb begin
      cnt_d    = DB_RELOAD;
      stable_d = stable_q;
      press_d  = 1'b0;
      if (sync_q[1] != stable_q) begin
         if (cnt_q == '0) begin
            stable_d = sync_q[1];
            press_d  = sync_q[1];
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q   <= 2'b00;
         stable_q <= 1'b0;
         cnt_q    <= DB_RELOAD;
         press_q  <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], btn_raw};
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         press_q  <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Core clock sequencer: free-run, single-step and PC breakpoint halt.
// Breakpoint logic and HALT are built only when CPU_RUN_CTRL_BP_EN is defined.
//
// state | meaning
// ------+-----------------------------------------------
// WAIT  | idle, cpu_clk low, waiting for press or run
// HI    | cpu_clk high for DIV clk cycles
// LO    | cpu_clk low for DIV clk cycles, decide next
// HALT  | breakpoint hit, cpu_clk low, waiting for press
module cpu_run_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned DIV    = 25000000,
   parameter int unsigned DB_CYC = 500000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run_sw,
   input  logic             step_btn,
   input  logic             bp_en,
   input  logic [7:0]       bp_addr,
   input  logic [7:0]       pc,
   output logic             cpu_clk,
   output logic             halted,
   output logic [CYC_W-1:0] cycle_cnt,
   output logic [1:0]       state
);

   localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV - 1);

   logic [1:0]       run_sync_q;
   logic             run_s;
   logic             press;
   logic             bp_hit;
   run_state_e       state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [CYC_W-1:0] cnt_q, cnt_d;
   logic             cpu_clk_q;
   logic             halted_q;
   logic             enter_hi;

   assign run_s = run_sync_q[1];

   btn_debounce #(.DB_CYC(DB_CYC)) u_db (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (step_btn),
      .press   (press)
   );

   // pc has been stable for a full LO phase when it is compared, so it is
   // used directly without resynchronization.
`ifdef CPU_RUN_CTRL_BP_EN
   assign bp_hit = bp_en && (pc == bp_addr);
`else
   logic unused_bp;
   assign unused_bp = ^{bp_en, bp_addr, pc};
   assign bp_hit    = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      cnt_d    = cnt_q;
      enter_hi = 1'b0;
      case (state_q)
         WAIT: begin
            if (press || run_s) enter_hi = 1'b1;
         end
         HI: begin
            if (div_q == '0) begin
               state_d = LO;
               div_d   = DIV_RELOAD;
            end else begin
               div_d = div_q - 1'b1;
            end
         end
         LO: begin
            if (div_q == '0) begin
               if (bp_hit)     state_d  = HALT;
               else if (run_s) enter_hi = 1'b1;
               else            state_d  = WAIT;
            end else begin
               div_d = div_q - 1'b1;
            end
         end
`ifdef CPU_RUN_CTRL_BP_EN
         HALT: begin
            if (press) enter_hi = 1'b1;
         end
`endif
         default: state_d = WAIT;
      endcase
      // Every entry into HI is one issued core cycle.
      if (enter_hi) begin
         state_d = HI;
         div_d   = DIV_RELOAD;
         cnt_d   = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_sync_q <= 2'b00;
         state_q    <= WAIT;
         div_q      <= '0;
         cnt_q      <= '0;
         cpu_clk_q  <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         run_sync_q <= {run_sync_q[0], run_sw};
         state_q    <= state_d;
         div_q      <= div_d;
         cnt_q      <= cnt_d;
         cpu_clk_q  <= (state_d == HI);
`ifdef CPU_RUN_CTRL_BP_EN
         halted_q   <= (state_d == HALT);
`else
         halted_q   <= 1'b0;
`endif
      end
   end

   assign cpu_clk   = cpu_clk_q;
   assign halted    = halted_q;
   assign cycle_cnt = cnt_q;
   assign state     = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with DIV=4, DB_CYC=8; all outputs are
// sampled on the falling clk edge, inputs change on the falling edge.
module tb_cpu_run_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        run_sw = 1'b0;
   logic        step_btn = 1'b0;
   logic        bp_en = 1'b0;
   logic [7:0]  bp_addr = 8'h00;
   logic [7:0]  pc;
   logic        cpu_clk;
   logic        halted;
   logic [15:0] cycle_cnt;
   logic [1:0]  state;

   int n_checks = 0;
   int n_fail   = 0;

   cpu_run_ctrl #(.DIV(4), .DB_CYC(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .run_sw    (run_sw),
      .step_btn  (step_btn),
      .bp_en     (bp_en),
      .bp_addr   (bp_addr),
      .pc        (pc),
      .cpu_clk   (cpu_clk),
      .halted    (halted),
      .cycle_cnt (cycle_cnt),
      .state     (state)
   );

   always #5 clk = ~clk;

   // Core PC model: advances one instruction per cpu_clk rise.
   always @(posedge cpu_clk or negedge reset) begin
      if (!reset) pc <= 8'h00;
      else        pc <= pc + 8'h04;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
   endtask

   task automatic meas(output int hi, output int lo);
      hi = 0;
      lo = 0;
      while (cpu_clk === 1'b1 && hi < 50) begin hi++; tick(1); end
      while (cpu_clk === 1'b0 && lo < 50) begin lo++; tick(1); end
   endtask

   // Watch n falling edges, release the button at edge rel_at.
   task automatic watch(input int n, input int rel_at,
                        output int rises, output int highs, output int first);
      logic prev;
      prev  = cpu_clk;
      rises = 0;
      highs = 0;
      first = -1;
      for (int i = 1; i <= n; i++) begin
         tick(1);
         if (cpu_clk === 1'b1 && prev !== 1'b1) begin
            rises++;
            if (first < 0) first = i;
         end
         if (cpu_clk === 1'b1) highs++;
         prev = cpu_clk;
         if (i == rel_at) step_btn = 1'b0;
      end
   endtask

   initial begin
      int k, hi, lo, rises, highs, first, bhi;

      // Reset state
      run_sw = 1'b1;
      tick(1);
      check("rst_cpu_clk", cpu_clk, 0);
      check("rst_halted", halted, 0);
      check("rst_cycle_cnt", cycle_cnt, 0);
      check("rst_state", state, 0);

      // Run mode
      tick(1);
      reset = 1'b1;
      k = 0;
      while (cpu_clk !== 1'b1 && k < 10) begin tick(1); k++; end
      check("run_first_rise", k, 3);
      meas(hi, lo);
      check("run_hi1", hi, 4);
      check("run_lo1", lo, 4);
      check("run_cnt2", cycle_cnt, 2);
      meas(hi, lo);
      check("run_hi2", hi, 4);
      check("run_lo2", lo, 4);
      tick(56);
      check("run_cnt10", cycle_cnt, 10);
      check("run_cpu_clk10", cpu_clk, 1);

      // Step mode, clean 20-cycle press
      run_sw = 1'b0;
      do_reset();
      tick(5);
      check("step_idle_state", state, 0);
      step_btn = 1'b1;
      watch(50, 20, rises, highs, first);
      check("step_rises", rises, 1);
      check("step_highs", highs, 4);
      check("step_first", first, 11);
      check("step_cnt", cycle_cnt, 1);
      check("step_state", state, 0);

      // Bouncing press
      do_reset();
      tick(5);
      bhi = 0;
      for (int i = 0; i < 30; i++) begin
         step_btn = ((i / 3) % 2 == 0);
         tick(1);
         if (cpu_clk === 1'b1) bhi++;
      end
      check("bounce_quiet", bhi, 0);
      step_btn = 1'b1;
      watch(60, 40, rises, highs, first);
      check("bounce_rises", rises, 1);
      check("bounce_first", first, 11);
      check("bounce_highs", highs, 4);
      check("bounce_cnt", cycle_cnt, 1);

      // Breakpoint at PC 0x0C in run mode
      run_sw  = 1'b1;
      bp_en   = 1'b1;
      bp_addr = 8'h0C;
      do_reset();
      tick(26);
      check("bp_pre_halted", halted, 0);
      check("bp_pre_state", state, 2);
      tick(1);
`ifdef CPU_RUN_CTRL_BP_EN
      check("bp_halted", halted, 1);
      check("bp_state", state, 3);
      check("bp_cnt", cycle_cnt, 3);
      check("bp_cpu_clk", cpu_clk, 0);
      watch(20, 0, rises, highs, first);
      check("bp_stuck_rises", rises, 0);
      check("bp_still_halted", halted, 1);
      step_btn = 1'b1;
      watch(40, 20, rises, highs, first);
      check("bp_resume_rises", rises, 4);
      check("bp_resume_first", first, 11);
      check("bp_resume_cnt", cycle_cnt, 7);
      check("bp_resume_halted", halted, 0);
`else
      check("nobp_halted", halted, 0);
      check("nobp_state", state, 1);
      check("nobp_cnt", cycle_cnt, 4);
      check("nobp_cpu_clk", cpu_clk, 1);
`endif
      bp_en = 1'b0;

      // run_sw drops during HI: that cycle completes, then WAIT
      run_sw = 1'b1;
      do_reset();
      tick(3);
      check("ms_hi_start", cpu_clk, 1);
      tick(1);
      run_sw = 1'b0;
      tick(2);
      check("ms_hi_end", cpu_clk, 1);
      tick(1);
      check("ms_lo_start", cpu_clk, 0);
      check("ms_lo_state", state, 2);
      tick(3);
      check("ms_lo_end", state, 2);
      tick(1);
      check("ms_wait", state, 0);
      watch(30, 0, rises, highs, first);
      check("ms_no_rises", rises, 0);
      check("ms_cnt", cycle_cnt, 1);

      // Asynchronous reset in the middle of HI
      run_sw = 1'b1;
      do_reset();
      tick(11);
      check("rmid_cnt_pre", cycle_cnt, 2);
      tick(1);
      check("rmid_hi_pre", cpu_clk, 1);
      reset = 1'b0;
      #1;
      check("rmid_cpu_clk", cpu_clk, 0);
      check("rmid_cnt", cycle_cnt, 0);
      check("rmid_state", state, 0);
      tick(1);
      reset = 1'b1;
      tick(1);
      check("rmid_state_rel", state, 0);
      check("rmid_cpu_clk_rel", cpu_clk, 0);
      tick(2);
      check("rmid_restart", cpu_clk, 1);
      check("rmid_restart_cnt", cycle_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step/breakpoint controller that sequences the MIPS core clock on the FPGA prototype. It derives the core clock from the 50 MHz board clock. Three modes: free-running, single-step from a debounced push-button, or halt when the 8-bit PC matches a switch-set breakpoint. It sits between the board clock and the processor, taking the place of a fixed one-second divider, so the 7-segment display can be inspected at any instruction.

## Interface
- DIV, 25000000: board-clock cycles per cpu_clk half-period; legal 1..2^26-1
- DB_CYC, 500000: board-clock cycles the button must be stable before a press is accepted; legal 1..2^20-1
- clk  input  1  50 MHz board clock; all logic on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- run_sw  input  1  raw switch; 1 = run mode, 0 = step mode
- step_btn  input  1  raw push-button, active-high, bouncy
- bp_en  input  1  breakpoint enable
- bp_addr  input  8  breakpoint PC, low byte
- pc  input  8  core PC low byte, produced in the cpu_clk domain
- cpu_clk  output  1  registered core clock
- halted  output  1  high while in HALT
- cycle_cnt  output  16  core cycles issued since reset
- state  output  2  FSM state encoding

## Operation
- Reset values: cpu_clk=0, halted=0, cycle_cnt=0, state=WAIT, divider count=0, synchronizers=0.
- run_sw passes through a 2-flop synchronizer.
- step_btn is conditioned by a sub-module into a one-clk press pulse.
- States:
  - WAIT (00): cpu_clk=0. A press goes to HI. If run_sw_s=1, goes to HI; a press in the same cycle counts once.
  - HI (01): cpu_clk=1 for DIV clk cycles, then LO.
  - LO (10): cpu_clk=0 for DIV clk cycles. On the last cycle, checked in priority order:
    - breakpoint hit goes to HALT
    - else run_sw_s=1 goes to HI
    - else goes to WAIT
  - HALT (11): cpu_clk=0, halted=1. A press goes to HI. run_sw is ignored in HALT.
- Breakpoint hit = bp_en && (pc == bp_addr). pc is sampled on the last LO cycle, when it has been stable for DIV cycles, so no synchronizer is needed on pc.
- Resuming from HALT issues exactly one core cycle before the breakpoint is re-evaluated, so a breakpoint PC does not re-halt immediately.
- cycle_cnt increments by 1 on every transition into HI. It wraps 0xFFFF -> 0x0000.
- Mode change mid-cycle: the current HI/LO cycle always completes; the new mode takes effect at the end of LO.
- Presses received during HI or LO are dropped and not queued.
- Reset mid-cycle: cpu_clk falls asynchronously to 0, and the FSM returns to WAIT.

## Timing
- Run mode: cpu_clk period is exactly 2*DIV clk cycles with 50% duty and no glitches, since cpu_clk is a flop output.
- Step press: the press pulse at edge t gives cpu_clk=1 from edge t+1 for DIV cycles, then 0 for DIV cycles.
- Debounce latency: 2 sync cycles plus DB_CYC stable cycles from the settled button edge to the press pulse.
- One pulse per press. Release must also be stable for DB_CYC before the next press is recognized.
- Breakpoint to halt: halted rises 1 clk after the last LO cycle. cpu_clk stays low.

## Configuration
- CPU_RUN_CTRL_BP_EN defined: breakpoint compare and the HALT state are compiled in.
- Macro undefined:
  - bp_en, bp_addr and pc are unused
  - HALT is unreachable and halted is tied to 0
  - state encoding 11 never appears

## Structure
- Shared package cpu_ctrl_pkg holds:
  - state encoding constants WAIT/HI/LO/HALT
  - the cycle_cnt width constant (16)
- Sub-module btn_debounce(clk, reset, btn_raw, press): 2-flop sync, stability counter, rising-edge one-shot.
- Top-level FSM, divider counter and cycle counter live in cpu_run_ctrl.

## Test plan
All scenarios use DIV=4, DB_CYC=8.
- Run mode: reset release, run_sw=1.
  - First cpu_clk rise within 4 clk, then period exactly 8 clk.
  - cycle_cnt=10 after 10 rises.
- Step mode: run_sw=0, clean 20-cycle press.
  - Exactly one cpu_clk pulse, 4 clk high.
  - cycle_cnt=1; state returns to 00.
- Bounce: button toggles every 3 clk for 30 clk, then holds high.
  - One press pulse 10 clk after hold start; one cpu_clk pulse total.
- Breakpoint: run mode, bp_en=1, bp_addr=0x0C, pc model increments by 4 per cpu_clk rise from 0.
  - halted=1 after the 3rd cycle (pc=0x0C), cpu_clk stuck low.
  - A press gives one cycle, then free-running resumes.
- Mode switch: run_sw drops during HI.
  - That cycle completes its full 8 clk, then state=00 with no further pulses.
- Reset mid-HI: reset=0 for 1 clk.
  - cpu_clk=0 and cycle_cnt=0 immediately.
  - state=00 after release.
